// File: rtl/vm_pkg.sv
// Shared types for the change dispenser: coin codes and values, FSM states
// and the cents type.
package vm_pkg;

  typedef logic [7:0] cents_t;
  typedef logic [7:0] coin_cnt_t;

  // Coin codes share one encoding across load_sel and hop_sel.
  typedef enum logic [1:0] {
    COIN_NICKEL  = 2'b00,
    COIN_DIME    = 2'b01,
    COIN_QUARTER = 2'b10,
    COIN_NONE    = 2'b11
  } coin_t;

  localparam cents_t NICKEL_VAL  = 8'd5;
  localparam cents_t DIME_VAL    = 8'd10;
  localparam cents_t QUARTER_VAL = 8'd25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SELECT = 2'b01,
    ST_REQ    = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  function automatic cents_t coin_value(input coin_t c);
    case (c)
      COIN_NICKEL:  return NICKEL_VAL;
      COIN_DIME:    return DIME_VAL;
      COIN_QUARTER: return QUARTER_VAL;
      default:      return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Hopper handshake between the dispenser controller (master) and the coin
// hopper (slave).
// Handshake: the master raises hop_req with hop_sel and holds both stable
// until it samples hop_ack high on a clk edge; that edge completes the coin
// and hop_req drops. hop_ack seen while hop_req is low has no effect.
interface change_dispense_ctrl_if;
  logic       hop_req;
  logic [1:0] hop_sel;
  logic       hop_ack;

  modport master (output hop_req, output hop_sel, input hop_ack);
  modport slave  (input hop_req, input hop_sel, output hop_ack);
endinterface

// File: rtl/vm_coin_select.sv
// Greedy coin pick: largest coin not exceeding the amount owed that is
// still in stock.
module vm_coin_select
  import vm_pkg::*;
(
  input  cents_t    remaining,
  input  coin_cnt_t cnt_nickel,
  input  coin_cnt_t cnt_dime,
  input  coin_cnt_t cnt_quarter,
  output logic      valid,
  output coin_t     sel
);

  always_comb begin
    valid = 1'b0;
    sel   = COIN_NICKEL;
    if (remaining >= QUARTER_VAL && cnt_quarter != 8'd0) begin
      valid = 1'b1;
      sel   = COIN_QUARTER;
    end else if (remaining >= DIME_VAL && cnt_dime != 8'd0) begin
      valid = 1'b1;
      sel   = COIN_DIME;
    end else if (remaining >= NICKEL_VAL && cnt_nickel != 8'd0) begin
      valid = 1'b1;
      sel   = COIN_NICKEL;
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change dispenser controller: pays out a requested amount one coin at a
// time through the hopper handshake, tracking per-denomination inventory.
module change_dispense_ctrl
  import vm_pkg::*;
#(
  parameter int unsigned INIT_CNT    = 20,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  cents_t                        change_amt,
  input  logic                          load,
  input  logic [1:0]                    load_sel,
  input  coin_cnt_t                     load_cnt,
  change_dispense_ctrl_if.master        hop,
  output logic                          busy,
  output logic                          done,
  output logic                          short,
  output logic                          fault,
  output cents_t                        remaining,
  output logic [2:0]                    empty,
  output state_t                        dbg_state
);

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  state_t           state, state_nx;
  coin_t            sel_q;
  logic [TMO_W-1:0] tmo_cnt;
  coin_cnt_t        cnt_nickel, cnt_dime, cnt_quarter;

  logic  pick_valid;
  coin_t pick_sel;
  logic  take_start;
  logic  ack_hit;
  logic  tmo_hit;

  vm_coin_select u_select (
    .remaining   (remaining),
    .cnt_nickel  (cnt_nickel),
    .cnt_dime    (cnt_dime),
    .cnt_quarter (cnt_quarter),
    .valid       (pick_valid),
    .sel         (pick_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    take_start = 1'b0;
    ack_hit    = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          take_start = 1'b1;
          state_nx   = ST_SELECT;
        end
      end
      ST_SELECT: begin
        state_nx = pick_valid ? ST_REQ : ST_DONE;
      end
      ST_REQ: begin
        if (hop.hop_ack) begin
          ack_hit  = 1'b1;
          state_nx = ST_SELECT;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Outputs decode straight from the state so an asynchronous reset
  // drops hop_req without waiting for a clock.
  assign hop.hop_req = (state == ST_REQ);
  assign hop.hop_sel = sel_q;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign dbg_state   = state;
  assign empty       = {cnt_quarter == 8'd0, cnt_dime == 8'd0, cnt_nickel == 8'd0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= 8'd0;
      short     <= 1'b0;
      fault     <= 1'b0;
      sel_q     <= COIN_NICKEL;
      tmo_cnt   <= '0;
    end else begin
      if (take_start) begin
        remaining <= change_amt;
        short     <= 1'b0;
        fault     <= 1'b0;
      end
      if (state == ST_SELECT) begin
        tmo_cnt <= '0;
        if (pick_valid) begin
          sel_q <= pick_sel;
        end else begin
          short <= (remaining != 8'd0);
        end
      end
      // A timeout leaves remaining untouched; it is non-zero here because a
      // coin no larger than remaining was picked.
      if (state == ST_REQ) begin
        if (ack_hit) begin
          remaining <= remaining - coin_value(sel_q);
        end else if (tmo_hit) begin
          fault <= 1'b1;
          short <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_nickel  <= 8'(INIT_CNT);
      cnt_dime    <= 8'(INIT_CNT);
      cnt_quarter <= 8'(INIT_CNT);
    end else begin
      if (state == ST_IDLE && load) begin
        case (coin_t'(load_sel))
          COIN_NICKEL:  cnt_nickel  <= load_cnt;
          COIN_DIME:    cnt_dime    <= load_cnt;
          COIN_QUARTER: cnt_quarter <= load_cnt;
          default:      ;
        endcase
      end
      if (ack_hit) begin
        case (sel_q)
          COIN_NICKEL:  if (cnt_nickel  != 8'd0) cnt_nickel  <= cnt_nickel  - 8'd1;
          COIN_DIME:    if (cnt_dime    != 8'd0) cnt_dime    <= cnt_dime    - 8'd1;
          COIN_QUARTER: if (cnt_quarter != 8'd0) cnt_quarter <= cnt_quarter - 8'd1;
          default:      ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Bench for change_dispense_ctrl: directed scenarios plus randomized payouts
// checked against a greedy arithmetic model of the coin inventory.
module tb_change_dispense_ctrl;
  import vm_pkg::*;

  localparam int INIT_CNT    = 20;
  localparam int ACK_TIMEOUT = 16;

  logic       clk, rst_n, start, load, hop_ack;
  logic [7:0] change_amt, load_cnt, remaining;
  logic [1:0] load_sel;
  logic       hop_req;
  logic [1:0] hop_sel;
  logic       busy, done, short, fault;
  logic [2:0] empty;
  state_t     dbg_state;

  change_dispense_ctrl_if hop_if();
  assign hop_if.hop_ack = hop_ack;
  assign hop_req        = hop_if.hop_req;
  assign hop_sel        = hop_if.hop_sel;

  change_dispense_ctrl #(.INIT_CNT(INIT_CNT), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .change_amt(change_amt),
    .load(load), .load_sel(load_sel), .load_cnt(load_cnt), .hop(hop_if),
    .busy(busy), .done(done), .short(short), .fault(fault),
    .remaining(remaining), .empty(empty), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state: index 0 nickel, 1 dime, 2 quarter
  int m_cnt [3];
  int m_val [3] = '{5, 10, 25};
  logic [1:0] exp_q [$];
  logic [1:0] got_q [$];

  int   res_first_req, res_done_cyc, res_max_req, res_rem;
  bit   res_done_seen, res_short, res_fault, res_busy_first, res_done_after, res_busy_after;
  logic [2:0] res_empty;

  function automatic void model_payout(input int amt, input bit stall, output int rem_o, output bit fault_o);
    int rem;
    bit go;
    rem = amt;
    go = 1'b1;
    fault_o = 1'b0;
    exp_q.delete();
    while (go) begin
      go = 1'b0;
      for (int k = 2; k >= 0; k--) begin
        if (!go && !fault_o && m_val[k] <= rem && m_cnt[k] > 0) begin
          exp_q.push_back(2'(k));
          if (stall) fault_o = 1'b1;
          else begin
            rem -= m_val[k];
            m_cnt[k]--;
            go = 1'b1;
          end
        end
      end
    end
    rem_o = rem;
  endfunction

  function automatic string exp_str();
    string s = "";
    foreach (exp_q[i]) s = $sformatf("%s%0d,", s, m_val[exp_q[i]]);
    return s;
  endfunction

  function automatic string got_str();
    string s = "";
    foreach (got_q[i]) s = $sformatf("%s%0d,", s, (got_q[i] == 2'b11) ? 0 : m_val[got_q[i]]);
    return s;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [1:0] sel, input logic [7:0] cnt);
    load = 1'b1;
    load_sel = sel;
    load_cnt = cnt;
    step();
    load = 1'b0;
  endtask

  // Runs one payout acting as the hopper; records what the DUT asked for.
  task automatic run_payout(input logic [7:0] amt, input int ack_delay, input bit no_ack,
                            input bit noise, input int inject_at, input logic [7:0] inject_amt);
    int c, req_age, run_len;
    got_q.delete();
    res_done_seen = 0; res_first_req = -1; res_done_cyc = -1; res_max_req = 0;
    start = 1'b1;
    change_amt = amt;
    step();
    start = 1'b0;
    load = 1'b0;
    res_busy_first = busy;
    c = 1; req_age = 0; run_len = 0;
    while (c < 600 && !res_done_seen) begin
      start = 1'b0; load = 1'b0; hop_ack = 1'b0;
      if (hop_req) begin
        if (req_age == 0) begin
          got_q.push_back(hop_sel);
          if (res_first_req < 0) res_first_req = c;
        end
        if (!no_ack && req_age == ack_delay) hop_ack = 1'b1;
        req_age++; run_len++;
        if (run_len > res_max_req) res_max_req = run_len;
      end else begin
        req_age = 0; run_len = 0;
        if (noise) hop_ack = 1'($urandom_range(0, 1));
      end
      if (done) begin
        res_done_seen = 1; res_done_cyc = c; res_short = short; res_fault = fault;
        res_rem = int'(remaining); res_empty = empty;
      end
      if (c == inject_at) begin
        start = 1'b1; change_amt = inject_amt; load = 1'b1; load_sel = 2'b00; load_cnt = 8'd0;
      end
      if (!res_done_seen) begin
        step();
        c++;
      end
    end
    hop_ack = 1'b0; start = 1'b0; load = 1'b0;
    step();
    res_done_after = done;
    res_busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; load = 1'b0; hop_ack = 1'b0;
    change_amt = 8'd0; load_sel = 2'b00; load_cnt = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hop_req !== 1'b0) begin errors++; $display("FAIL reset_hop_req: got %b exp 0", hop_req); end
    checks++; if (hop_sel !== 2'b00) begin errors++; $display("FAIL reset_hop_sel: got %b exp 00", hop_sel); end
    checks++; if ({busy, done, short, fault} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {busy, done, short, fault}); end
    checks++; if (remaining !== 8'd0) begin errors++; $display("FAIL reset_remaining: got %0d exp 0", remaining); end
    checks++; if (empty !== 3'b000) begin errors++; $display("FAIL reset_empty: got %b exp 000", empty); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
    checks++; if ({dut.cnt_nickel, dut.cnt_dime, dut.cnt_quarter} !== {3{8'(INIT_CNT)}}) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d/%0d exp %0d", dut.cnt_nickel, dut.cnt_dime, dut.cnt_quarter, INIT_CNT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b exp 0", busy); end
    for (int k = 0; k < 3; k++) m_cnt[k] = INIT_CNT;
  endtask

  task automatic test_basic_40();
    int e_rem; bit e_fault;
    model_payout(40, 1'b0, e_rem, e_fault);
    run_payout(8'd40, 1, 1'b0, 1'b0, -1, 8'd0);
    checks++; if (res_done_seen !== 1'b1) begin errors++; $display("FAIL basic_done_seen: got %b exp 1", res_done_seen); end
    checks++; if (got_str() != exp_str()) begin errors++; $display("FAIL basic_coins: got %s exp %s", got_str(), exp_str()); end
    checks++; if (res_rem !== e_rem) begin errors++; $display("FAIL basic_remaining: got %0d exp %0d", res_rem, e_rem); end
    checks++; if (res_short !== 1'b0 || res_fault !== 1'b0) begin errors++; $display("FAIL basic_short_fault: got %b%b exp 00", res_short, res_fault); end
    checks++; if (res_first_req !== 2) begin errors++; $display("FAIL basic_req_latency: got %0d exp 2", res_first_req); end
    checks++; if (res_busy_first !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", res_busy_first); end
    checks++; if (res_done_after !== 1'b0 || res_busy_after !== 1'b0) begin errors++; $display("FAIL basic_done_width: got done=%b busy=%b exp 0 0", res_done_after, res_busy_after); end
    checks++; if (int'(dut.cnt_quarter) !== m_cnt[2]) begin errors++; $display("FAIL basic_quarter_cnt: got %0d exp %0d", dut.cnt_quarter, m_cnt[2]); end
  endtask

  task automatic test_load_quarter_zero();
    int e_rem; bit e_fault;
    drive_load(2'b11, 8'd0);
    checks++; if ({int'(dut.cnt_nickel), int'(dut.cnt_dime), int'(dut.cnt_quarter)} !== {m_cnt[0], m_cnt[1], m_cnt[2]}) begin
      errors++; $display("FAIL load_sel3_ignored: got %0d/%0d/%0d exp %0d/%0d/%0d", dut.cnt_nickel, dut.cnt_dime, dut.cnt_quarter, m_cnt[0], m_cnt[1], m_cnt[2]);
    end
    drive_load(2'b10, 8'd0);
    m_cnt[2] = 0;
    model_payout(50, 1'b0, e_rem, e_fault);
    run_payout(8'd50, 0, 1'b0, 1'b1, -1, 8'd0);
    checks++; if (got_str() != exp_str()) begin errors++; $display("FAIL q0_coins: got %s exp %s", got_str(), exp_str()); end
    checks++; if (res_empty !== {m_cnt[2] == 0, m_cnt[1] == 0, m_cnt[0] == 0}) begin errors++; $display("FAIL q0_empty: got %b exp 100", res_empty); end
    checks++; if (res_short !== (e_rem != 0)) begin errors++; $display("FAIL q0_short: got %b exp %b", res_short, e_rem != 0); end
  endtask

  task automatic test_residue_37();
    int e_rem; bit e_fault;
    drive_load(2'b10, 8'd20);
    m_cnt[2] = 20;
    model_payout(37, 1'b0, e_rem, e_fault);
    run_payout(8'd37, 2, 1'b0, 1'b0, -1, 8'd0);
    checks++; if (got_str() != exp_str()) begin errors++; $display("FAIL residue_coins: got %s exp %s", got_str(), exp_str()); end
    checks++; if (res_rem !== e_rem) begin errors++; $display("FAIL residue_remaining: got %0d exp %0d", res_rem, e_rem); end
    checks++; if (res_short !== 1'b1 || res_fault !== 1'b0) begin errors++; $display("FAIL residue_short_fault: got %b%b exp 10", res_short, res_fault); end
  endtask

  task automatic test_timeout();
    int e_rem; bit e_fault;
    model_payout(75, 1'b1, e_rem, e_fault);
    run_payout(8'd75, 0, 1'b1, 1'b0, -1, 8'd0);
    checks++; if (res_max_req !== ACK_TIMEOUT) begin errors++; $display("FAIL tmo_req_cycles: got %0d exp %0d", res_max_req, ACK_TIMEOUT); end
    checks++; if (res_fault !== e_fault || res_short !== 1'b1) begin errors++; $display("FAIL tmo_fault_short: got %b%b exp %b1", res_fault, res_short, e_fault); end
    checks++; if (res_rem !== e_rem) begin errors++; $display("FAIL tmo_remaining: got %0d exp %0d", res_rem, e_rem); end
    checks++; if (got_str() != exp_str()) begin errors++; $display("FAIL tmo_coins: got %s exp %s", got_str(), exp_str()); end
    checks++; if (int'(dut.cnt_quarter) !== m_cnt[2]) begin errors++; $display("FAIL tmo_count: got %0d exp %0d", dut.cnt_quarter, m_cnt[2]); end
    repeat (5) step();
    checks++; if ({short, fault, busy} !== 3'b110) begin errors++; $display("FAIL tmo_hold: got %b exp 110", {short, fault, busy}); end
  endtask

  task automatic test_zero_amt();
    int e_rem; bit e_fault;
    model_payout(0, 1'b0, e_rem, e_fault);
    run_payout(8'd0, 0, 1'b0, 1'b0, -1, 8'd0);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL zero_no_req: got %0d reqs exp 0", got_q.size()); end
    checks++; if (res_done_cyc !== 2) begin errors++; $display("FAIL zero_done_cycle: got %0d exp 2", res_done_cyc); end
    checks++; if ({res_short, res_fault} !== 2'b00) begin errors++; $display("FAIL zero_flags_cleared: got %b exp 00", {res_short, res_fault}); end
  endtask

  task automatic test_idle_ack_ignored();
    for (int i = 0; i < 6; i++) begin
      hop_ack = 1'($urandom_range(0, 1));
      step();
      checks++; if (dbg_state !== ST_IDLE || hop_req !== 1'b0) begin errors++; $display("FAIL idle_ack: got state %0d req %b exp 0 0", dbg_state, hop_req); end
    end
    hop_ack = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int e_rem; bit e_fault;
    model_payout(40, 1'b0, e_rem, e_fault);
    run_payout(8'd40, 3, 1'b0, 1'b0, 3, 8'd200);
    checks++; if (got_str() != exp_str()) begin errors++; $display("FAIL busy_coins: got %s exp %s", got_str(), exp_str()); end
    checks++; if (res_rem !== e_rem) begin errors++; $display("FAIL busy_remaining: got %0d exp %0d", res_rem, e_rem); end
    checks++; if (int'(dut.cnt_nickel) !== m_cnt[0]) begin errors++; $display("FAIL busy_load_ignored: got %0d exp %0d", dut.cnt_nickel, m_cnt[0]); end
    checks++; if (res_busy_after !== 1'b0) begin errors++; $display("FAIL busy_start_ignored: got %b exp 0", res_busy_after); end
  endtask

  task automatic test_load_with_start();
    int e_rem; bit e_fault;
    load = 1'b1; load_sel = 2'b10; load_cnt = 8'd0;
    m_cnt[2] = 0;
    model_payout(30, 1'b0, e_rem, e_fault);
    run_payout(8'd30, 1, 1'b0, 1'b0, -1, 8'd0);
    checks++; if (got_str() != exp_str()) begin errors++; $display("FAIL load_start_coins: got %s exp %s", got_str(), exp_str()); end
    checks++; if (res_rem !== e_rem) begin errors++; $display("FAIL load_start_remaining: got %0d exp %0d", res_rem, e_rem); end
  endtask

  task automatic test_random();
    int e_rem, amt, dly, sel; bit e_fault, stall;
    logic [7:0] cnt;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 3);
        cnt = 8'($urandom_range(0, 30));
        drive_load(2'(sel), cnt);
        if (sel != 3) m_cnt[sel] = int'(cnt);
      end
      amt = $urandom_range(0, 255);
      dly = $urandom_range(0, 3);
      stall = ($urandom_range(0, 7) == 0);
      model_payout(amt, stall, e_rem, e_fault);
      run_payout(8'(amt), dly, stall, 1'($urandom_range(0, 1)), -1, 8'd0);
      checks++; if (res_done_seen !== 1'b1) begin errors++; $display("FAIL rnd_done it=%0d: got 0 exp 1", it); end
      checks++; if (got_str() != exp_str()) begin errors++; $display("FAIL rnd_coins it=%0d amt=%0d: got %s exp %s", it, amt, got_str(), exp_str()); end
      checks++; if (res_rem !== e_rem) begin errors++; $display("FAIL rnd_remaining it=%0d: got %0d exp %0d", it, res_rem, e_rem); end
      checks++; if ({res_short, res_fault} !== {(e_rem != 0) || e_fault, e_fault}) begin
        errors++; $display("FAIL rnd_flags it=%0d: got %b%b exp %b%b", it, res_short, res_fault, (e_rem != 0) || e_fault, e_fault);
      end
      checks++; if ({int'(dut.cnt_nickel), int'(dut.cnt_dime), int'(dut.cnt_quarter)} !== {m_cnt[0], m_cnt[1], m_cnt[2]}) begin
        errors++; $display("FAIL rnd_counts it=%0d: got %0d/%0d/%0d exp %0d/%0d/%0d", it, dut.cnt_nickel, dut.cnt_dime, dut.cnt_quarter, m_cnt[0], m_cnt[1], m_cnt[2]);
      end
    end
  endtask

  task automatic test_reset_mid_payout();
    bit seen_req, seen_done;
    drive_load(2'b10, 8'd5);
    start = 1'b1; change_amt = 8'd75;
    step();
    start = 1'b0;
    seen_req = 0;
    for (int i = 0; i < 10 && !seen_req; i++) begin
      if (hop_req) seen_req = 1;
      else step();
    end
    checks++; if (seen_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_seen: got 0 exp 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hop_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async: got req=%b busy=%b exp 0 0", hop_req, busy); end
    seen_done = 0;
    repeat (3) begin
      step();
      if (done) seen_done = 1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) m_cnt[k] = INIT_CNT;
    repeat (3) begin
      step();
      if (done) seen_done = 1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got 1 exp 0"); end
    checks++; if ({int'(dut.cnt_nickel), int'(dut.cnt_dime), int'(dut.cnt_quarter)} !== {m_cnt[0], m_cnt[1], m_cnt[2]}) begin
      errors++; $display("FAIL rstmid_counts: got %0d/%0d/%0d exp %0d", dut.cnt_nickel, dut.cnt_dime, dut.cnt_quarter, INIT_CNT);
    end
    checks++; if (remaining !== 8'd0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstmid_idle: got rem=%0d state=%0d exp 0 0", remaining, dbg_state); end
  endtask

  initial begin
    test_reset();
    test_basic_40();
    test_load_quarter_zero();
    test_residue_37();
    test_timeout();
    test_zero_amt();
    test_idle_ack_ignored();
    test_busy_ignore();
    test_load_with_start();
    test_random();
    test_reset_mid_payout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
